// File: rtl/wb2core_pkg.sv
// Shared types for the Wishbone-slave to core-memory bridge.
package wb2core_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DRAIN
  } wb2core_state_e;

endpackage

// File: rtl/wb2core.sv
// Wishbone B4 pipelined slave bridging onto a core-style req/gnt/rvalid device port.
// Tracks outstanding requests, stalls the bus, and drops responses of aborted cycles.
module wb2core
  import wb2core_pkg::*;
#(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int MaxOutstanding = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wb_cyc,
  input  logic            wb_stb,
  input  logic            wb_we,
  input  logic [DW/8-1:0] wb_sel,
  input  logic [AW-1:0]   wb_adr,
  input  logic [DW-1:0]   wb_dat_i,
  output logic [DW-1:0]   wb_dat_o,
  output logic            wb_ack,
  output logic            wb_err,
  output logic            wb_stall,
  output logic            dev_req,
  input  logic            dev_gnt,
  output logic            dev_we,
  output logic [DW/8-1:0] dev_be,
  output logic [AW-1:0]   dev_addr,
  output logic [DW-1:0]   dev_wdata,
  input  logic            dev_rvalid,
  input  logic [DW-1:0]   dev_rdata,
  input  logic            dev_err
);

  localparam int CW = $clog2(MaxOutstanding + 1);
  localparam logic [CW-1:0] MaxCnt = CW'(MaxOutstanding);

  wb2core_state_e state_q, state_d;
  logic [CW-1:0]  in_flight_q, in_flight_d;
  logic           req_valid_q;
  logic           accept;
  logic           rsp_take;

  // gnt feeds stall combinationally so a retiring request frees the register the same cycle
  assign wb_stall = (in_flight_q == MaxCnt) | (req_valid_q & ~dev_gnt) | (state_q == DRAIN);
  assign accept   = wb_cyc & wb_stb & ~wb_stall;
  // an rvalid with nothing outstanding is a device fault and is ignored
  assign rsp_take = dev_rvalid & (in_flight_q != '0);
  assign dev_req  = req_valid_q;

  always_comb begin
    in_flight_d = in_flight_q;
    if (accept & ~rsp_take)      in_flight_d = in_flight_q + CW'(1);
    else if (~accept & rsp_take) in_flight_d = in_flight_q - CW'(1);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = ACTIVE;
      ACTIVE: begin
        if (in_flight_d == '0) state_d = IDLE;
        else if (!wb_cyc)      state_d = DRAIN;
      end
      DRAIN:   if (in_flight_d == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_flight_q <= '0;
    end else begin
      state_q     <= state_d;
      in_flight_q <= in_flight_d;
    end
  end

  // request register: an accept can only coincide with a valid entry when gnt retires it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_valid_q <= 1'b0;
      dev_we      <= 1'b0;
      dev_be      <= '0;
      dev_addr    <= '0;
      dev_wdata   <= '0;
    end else if (accept) begin
      req_valid_q <= 1'b1;
      dev_we      <= wb_we;
      dev_be      <= wb_sel;
      dev_addr    <= wb_adr;
      dev_wdata   <= wb_dat_i;
    end else if (dev_gnt) begin
      req_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_ack   <= 1'b0;
      wb_err   <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack <= 1'b0;
      wb_err <= 1'b0;
      if (rsp_take && wb_cyc && state_q != DRAIN) begin
        if (dev_err) begin
          wb_err   <= 1'b1;
          wb_dat_o <= '0;
        end else begin
          wb_ack   <= 1'b1;
          wb_dat_o <= dev_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_wb2core.sv
// Randomized and directed bench for wb2core against a queue-based transaction model.
module tb_wb2core;
  localparam int AW = 32, DW = 32, SW = DW / 8, MAXO = 2;

  logic clk = 1'b0, rst_n = 1'b0;
  logic wb_cyc = 0, wb_stb = 0, wb_we = 0;
  logic [SW-1:0] wb_sel = '0;
  logic [AW-1:0] wb_adr = '0;
  logic [DW-1:0] wb_dat_i = '0, wb_dat_o;
  logic wb_ack, wb_err, wb_stall, dev_req, dev_we;
  logic dev_gnt = 0, dev_rvalid = 0, dev_err = 0;
  logic [SW-1:0] dev_be;
  logic [AW-1:0] dev_addr;
  logic [DW-1:0] dev_wdata, dev_rdata = '0;

  always #5 clk = ~clk;

  wb2core #(.AW(AW), .DW(DW), .MaxOutstanding(MAXO)) dut (
    .clk(clk), .rst_n(rst_n), .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
    .wb_sel(wb_sel), .wb_adr(wb_adr), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_ack(wb_ack), .wb_err(wb_err), .wb_stall(wb_stall), .dev_req(dev_req),
    .dev_gnt(dev_gnt), .dev_we(dev_we), .dev_be(dev_be), .dev_addr(dev_addr),
    .dev_wdata(dev_wdata), .dev_rvalid(dev_rvalid), .dev_rdata(dev_rdata), .dev_err(dev_err)
  );

  typedef struct packed {
    logic          we;
    logic [SW-1:0] sel;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
  } req_t;

  // model: accepted-not-granted requests, granted-not-answered count, abort flag
  req_t acc_q[$];
  int   n_dev;
  bit   drain;
  logic exp_ack, exp_err;
  logic [DW-1:0] exp_dat;
  int   n_chk, n_err, n_rsp;

  // per-cycle stimulus chosen by the caller before tick()
  logic m_cyc, m_stb, d_gnt, d_rv, d_err;
  req_t m_req;
  logic [DW-1:0] d_rdata;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic req_t mk(input logic we, input logic [SW-1:0] sel,
                              input logic [AW-1:0] adr, input logic [DW-1:0] dat);
    req_t r;
    r.we = we; r.sel = sel; r.adr = adr; r.dat = dat;
    return r;
  endfunction

  task automatic model_reset();
    acc_q.delete();
    n_dev = 0; drain = 0; exp_ack = 0; exp_err = 0; exp_dat = '0;
  endtask

  task automatic set_idle();
    m_cyc = 1; m_stb = 0; d_gnt = 0; d_rv = 0; d_err = 0; d_rdata = '0;
  endtask

  // one bus cycle: entered and left at posedge+1
  task automatic tick(output bit acc);
    bit exp_stall, rv_pop;
    int outs;
    req_t h;
    wb_cyc = m_cyc; wb_stb = m_stb; wb_we = m_req.we; wb_sel = m_req.sel;
    wb_adr = m_req.adr; wb_dat_i = m_req.dat;
    rv_pop = d_rv && (n_dev > 0);
    dev_gnt = d_gnt; dev_rvalid = rv_pop; dev_err = d_err; dev_rdata = d_rdata;
    #2;
    outs = acc_q.size() + n_dev;
    exp_stall = (outs >= MAXO) || (acc_q.size() > 0 && !d_gnt) || drain;
    chk("stall", wb_stall, exp_stall);
    chk("dev_req", dev_req, acc_q.size() > 0);
    chk("ack", wb_ack, exp_ack);
    chk("err", wb_err, exp_err);
    if (exp_ack || exp_err) chk("rdata", wb_dat_o, exp_dat);
    if (wb_ack || wb_err) n_rsp++;
    acc = m_cyc && m_stb && !exp_stall;
    if (rv_pop) n_dev--;
    if (d_gnt && acc_q.size() > 0) begin
      h = acc_q.pop_front();
      chk("dev_addr", dev_addr, h.adr);
      chk("dev_we", dev_we, h.we);
      chk("dev_be", dev_be, h.sel);
      chk("dev_wdata", dev_wdata, h.dat);
      n_dev++;
    end
    if (acc) acc_q.push_back(m_req);
    exp_ack = rv_pop && !d_err && m_cyc && !drain;
    exp_err = rv_pop && d_err && m_cyc && !drain;
    exp_dat = d_err ? '0 : d_rdata;
    outs = acc_q.size() + n_dev;
    if (!drain && !m_cyc && outs > 0) drain = 1;
    else if (drain && outs == 0) drain = 0;
    @(posedge clk); #1;
  endtask

  task automatic flush();
    bit acc;
    for (int i = 0; i < 30 && (acc_q.size() + n_dev > 0); i++) begin
      set_idle(); d_gnt = 1; d_rv = 1; d_rdata = $urandom; tick(acc);
    end
    chk("flush_done", acc_q.size() + n_dev, 0);
    set_idle(); tick(acc);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req"}, dev_req, 0);
    chk({tag, "_we"}, dev_we, 0);
    chk({tag, "_be"}, dev_be, 0);
    chk({tag, "_addr"}, dev_addr, 0);
    chk({tag, "_wdata"}, dev_wdata, 0);
    chk({tag, "_ack"}, wb_ack, 0);
    chk({tag, "_err"}, wb_err, 0);
    chk({tag, "_dat"}, wb_dat_o, 0);
    chk({tag, "_stall"}, wb_stall, 0);
  endtask

  initial begin
    bit acc, have;
    int k, r0, cyc_off;
    n_chk = 0; n_err = 0; n_rsp = 0;
    model_reset(); set_idle(); m_req = '0;
    #12;
    check_reset_outputs("rst");
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    // single read, minimum latency
    set_idle(); m_stb = 1; m_req = mk(0, 4'hF, 32'h100, 0); tick(acc);
    chk("rd_acc", acc, 1);
    set_idle(); d_gnt = 1; tick(acc);
    set_idle(); d_rv = 1; d_rdata = 32'hDEADBEEF; tick(acc);
    chk("rd_ack", wb_ack, 1);
    chk("rd_dat", wb_dat_o, 32'hDEADBEEF);
    set_idle(); tick(acc); tick(acc);

    // write pipeline
    k = 0; r0 = n_rsp;
    for (int c = 0; c < 30 && (k < 4 || acc_q.size() + n_dev > 0); c++) begin
      set_idle(); m_stb = (k < 4); m_req = mk(1, 4'hF, 32'h40 + 4 * k, k + 1);
      d_gnt = 1; d_rv = 1; tick(acc);
      if (acc) k++;
    end
    set_idle(); tick(acc);
    chk("wr_accepts", k, 4);
    chk("wr_acks", n_rsp - r0, 4);

    // outstanding limit
    k = 0;
    for (int c = 0; c < 10 && k < 2; c++) begin
      set_idle(); m_stb = 1; m_req = mk(0, 4'hF, 32'h300 + 4 * k, 0); d_gnt = 1; tick(acc);
      if (acc) k++;
    end
    set_idle(); m_stb = 1; m_req = mk(0, 4'h3, 32'h308, 0); d_gnt = 1;
    for (int c = 0; c < 3; c++) tick(acc);
    chk("lim_stall", wb_stall, 1);
    d_rv = 1; d_rdata = 32'h11; tick(acc);
    chk("lim_held", acc, 0);
    d_rv = 0; tick(acc);
    chk("lim_third", acc, 1);
    flush();

    // error response
    set_idle(); m_stb = 1; m_req = mk(0, 4'hF, 32'h200, 0); tick(acc);
    set_idle(); d_gnt = 1; tick(acc);
    set_idle(); d_rv = 1; d_err = 1; d_rdata = 32'hBAD0BAD0; tick(acc);
    chk("err_pulse", wb_err, 1);
    chk("err_noack", wb_ack, 0);
    chk("err_dat", wb_dat_o, 0);
    set_idle(); tick(acc);

    // abort with two in flight
    k = 0;
    for (int c = 0; c < 10 && k < 2; c++) begin
      set_idle(); m_stb = 1; m_req = mk(0, 4'hF, 32'h500 + 4 * k, 0); d_gnt = 1; tick(acc);
      if (acc) k++;
    end
    set_idle(); d_gnt = 1; tick(acc);
    r0 = n_rsp;
    set_idle(); m_cyc = 0; tick(acc);
    chk("abort_stall", wb_stall, 1);
    set_idle(); m_cyc = 0; d_rv = 1; d_rdata = 32'h55; tick(acc);
    set_idle(); m_cyc = 1; d_rv = 1; d_rdata = 32'h66; tick(acc);
    set_idle(); tick(acc);
    chk("abort_norsp", n_rsp - r0, 0);
    set_idle(); m_stb = 1; m_req = mk(0, 4'hF, 32'h600, 0); tick(acc);
    chk("abort_reaccept", acc, 1);
    flush();

    // reset mid-transaction
    set_idle(); m_stb = 1; m_req = mk(0, 4'hF, 32'h700, 0); tick(acc);
    set_idle(); m_stb = 1; m_req = mk(1, 4'hC, 32'h704, 32'h77); d_gnt = 1; tick(acc);
    set_idle(); tick(acc);
    chk("prerst_req", dev_req, 1);
    wb_stb = 0; dev_gnt = 0; dev_rvalid = 0;
    #1 rst_n = 0; #1;
    check_reset_outputs("midrst");
    model_reset();
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    set_idle(); m_stb = 1; m_req = mk(0, 4'hF, 32'h800, 0); tick(acc);
    chk("postrst_acc", acc, 1);
    set_idle(); d_gnt = 1; tick(acc);
    set_idle(); d_rv = 1; d_rdata = 32'hCAFEF00D; tick(acc);
    chk("postrst_ack", wb_ack, 1);
    chk("postrst_dat", wb_dat_o, 32'hCAFEF00D);
    set_idle(); tick(acc);

    // randomized traffic with occasional aborts
    have = 0; cyc_off = 0;
    for (int c = 0; c < 1500; c++) begin
      if (cyc_off > 0) cyc_off--;
      else if ($urandom_range(0, 59) == 0) cyc_off = $urandom_range(1, 4);
      if (!have && $urandom_range(0, 2) != 0) begin
        have = 1;
        m_req = mk(1'($urandom), 4'($urandom), $urandom, $urandom);
      end
      m_cyc = (cyc_off == 0);
      m_stb = have && m_cyc;
      d_gnt = (acc_q.size() > 0) && ($urandom_range(0, 1) == 1);
      d_rv = ($urandom_range(0, 1) == 1);
      d_err = ($urandom_range(0, 7) == 0);
      d_rdata = $urandom;
      tick(acc);
      if (acc) have = 0;
    end
    m_cyc = 1;
    flush();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
